// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared state encoding and default frame geometry
// for the OFDM cyclic-prefix removal block.
package ofdm_pkg;

  localparam int DEF_SYMBOL_LEN      = 64;
  localparam int DEF_CP_LEN          = 16;
  localparam int DEF_PREAMBLE_LEN    = 160;
  localparam int DEF_MAX_NUM_SYMBOLS = 10;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    LTF,
    CP,
    DATA
  } state_e;

endpackage

// File: rtl/axi_fifo_flop.sv
// axi_fifo_flop: single-entry registered AXI-stream stage
// with full-throughput valid/ready handoff.
module axi_fifo_flop #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready
);

  assign i_tready = ~o_tvalid | o_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
    end else if (i_tvalid && i_tready) begin
      o_tvalid <= 1'b1;
      o_tdata  <= i_tdata;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/ofdm_cp_remove.sv
// ofdm_cp_remove: drops preamble guard and cyclic prefixes, forwards LTF + data.
// Define OFDM_CP_REMOVE_BACKOFF_EN to start each FFT window CP_BACKOFF early.
module ofdm_cp_remove
  import ofdm_pkg::*;
#(
  parameter int SYMBOL_LEN        = DEF_SYMBOL_LEN,
  parameter int CYCLIC_PREFIX_LEN = DEF_CP_LEN,
  parameter int PREAMBLE_LEN      = DEF_PREAMBLE_LEN,
  parameter int MAX_NUM_SYMBOLS   = DEF_MAX_NUM_SYMBOLS,
  parameter int CP_BACKOFF        = 4,
  localparam int NW = $clog2(MAX_NUM_SYMBOLS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NW-1:0] num_symbols,
  input  logic          num_symbols_valid,
  input  logic [31:0]   i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          i_tready,
  input  logic          i_sof,
  output logic [31:0]   o_tdata,
  output logic          o_tlast,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic          o_sof,
  output logic          o_eof
);

  localparam int CW        = $clog2(PREAMBLE_LEN);
  localparam int GUARD_LEN = PREAMBLE_LEN - 2 * SYMBOL_LEN;

  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_LEN - 1);
  localparam logic [CW-1:0] SYM_END   = CW'(SYMBOL_LEN - 1);
  localparam logic [CW-1:0] LTF_END   = CW'(2 * SYMBOL_LEN - 1);
  localparam logic [CW-1:0] CP_END    = CW'(CYCLIC_PREFIX_LEN - 1);

  // First CP after the LTF is shortened; later CPs absorb the data tail.
`ifdef OFDM_CP_REMOVE_BACKOFF_EN
  localparam logic [CW-1:0] CP_START = CW'(CP_BACKOFF);
  if (CP_BACKOFF >= CYCLIC_PREFIX_LEN) begin : g_bad_backoff
    $error("CP_BACKOFF must be smaller than CYCLIC_PREFIX_LEN");
  end
`else
  localparam logic [CW-1:0] CP_START = '0;
  localparam int unused_backoff = CP_BACKOFF;
`endif

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NW-1:0] rem, rem_n;
  logic [NW-1:0] num_reg;

  logic fwd_st;
  logic acc;
  logic f_ready;
  logic fwd;
  logic f_last;
  logic f_sof;
  logic f_eof;
  logic unused_tlast;

  assign unused_tlast = i_tlast;

  assign fwd_st   = (state == LTF) || (state == DATA);
  assign i_tready = ~reset & (fwd_st ? f_ready : 1'b1);
  assign acc      = i_tvalid & i_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rem     <= '0;
      num_reg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      if (num_symbols_valid) begin
        num_reg <= (num_symbols > NW'(MAX_NUM_SYMBOLS))
                 ? NW'(MAX_NUM_SYMBOLS) : num_symbols;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rem_n   = rem;
    fwd     = 1'b0;
    f_last  = 1'b0;
    f_sof   = 1'b0;
    f_eof   = 1'b0;
    if (acc && i_sof) begin
      rem_n = num_reg;
      if (GUARD_LEN == 1) begin
        state_n = LTF;
        cnt_n   = '0;
      end else begin
        state_n = GUARD;
        cnt_n   = CW'(1);
      end
    end else if (acc) begin
      unique case (state)
        IDLE: begin
          cnt_n = '0;
        end
        GUARD: begin
          if (cnt == GUARD_END) begin
            state_n = LTF;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        LTF: begin
          fwd    = 1'b1;
          f_sof  = (cnt == '0);
          f_last = (cnt == SYM_END) || (cnt == LTF_END);
          if (cnt == LTF_END) begin
            f_eof   = (rem == '0);
            state_n = (rem == '0) ? IDLE : CP;
            cnt_n   = (rem == '0) ? '0 : CP_START;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        CP: begin
          if (cnt == CP_END) begin
            state_n = DATA;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        DATA: begin
          fwd = 1'b1;
          if (cnt == SYM_END) begin
            f_last  = 1'b1;
            f_eof   = (rem == NW'(1));
            rem_n   = rem - NW'(1);
            state_n = (rem == NW'(1)) ? IDLE : CP;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  logic [34:0] f_out;

  axi_fifo_flop #(
    .WIDTH(35)
  ) u_out (
    .clk     (clk),
    .reset   (reset),
    .i_tdata ({f_eof, f_sof, f_last, i_tdata}),
    .i_tvalid(fwd),
    .i_tready(f_ready),
    .o_tdata (f_out),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  assign o_eof   = f_out[34];
  assign o_sof   = f_out[33];
  assign o_tlast = f_out[32];
  assign o_tdata = f_out[31:0];

endmodule

// File: doc/ofdm_cp_remove.md
OFDM_CP_REMOVE -- requirements
Module: ofdm_cp_remove

Interface
REQ-001 SHALL have parameter SYMBOL_LEN, default 64, FFT symbol length in samples.
REQ-002 SHALL have parameter CYCLIC_PREFIX_LEN, default 16, data-symbol CP length.
REQ-003 SHALL have parameter PREAMBLE_LEN, default 160, samples from sof to first data symbol; last 2*SYMBOL_LEN are the two LTF symbols.
REQ-004 SHALL have parameter MAX_NUM_SYMBOLS, default 10; NW = $clog2(MAX_NUM_SYMBOLS+1).
REQ-005 SHALL have parameter CP_BACKOFF, default 4, used only under REQ-030.
REQ-006 SHALL have ports: clk in 1 compute clock; reset in 1, synchronous active-high reset.
REQ-007 SHALL have ports: num_symbols in NW, data symbols per frame; num_symbols_valid in 1, load strobe.
REQ-008 SHALL have ports: i_tdata in 32 (I[31:16],Q[15:0]); i_tlast in 1, ignored; i_tvalid in 1; i_tready out 1; i_sof in 1, first preamble sample, qualified by i_tvalid.
REQ-009 SHALL have ports: o_tdata out 32; o_tlast out 1, last sample of each symbol; o_tvalid out 1; o_tready in 1; o_sof out 1, first LTF1 sample; o_eof out 1, last sample of frame.

Function
REQ-010 SHALL implement states IDLE, GUARD, LTF, CP, DATA; sample counter width $clog2(PREAMBLE_LEN).
REQ-011 IDLE: SHALL consume and discard every input beat without i_sof; beat with i_sof -> GUARD, counter counts that beat.
REQ-012 GUARD: SHALL discard first PREAMBLE_LEN-2*SYMBOL_LEN preamble beats (incl. sof beat), then -> LTF.
REQ-013 LTF: SHALL forward 2*SYMBOL_LEN beats; o_tlast on beats SYMBOL_LEN and 2*SYMBOL_LEN; then -> CP if latched count > 0, else IDLE.
REQ-014 CP: SHALL discard CYCLIC_PREFIX_LEN beats, then -> DATA.
REQ-015 DATA: SHALL forward SYMBOL_LEN beats, o_tlast on last; decrement remaining-symbol count; -> CP if count remains, else IDLE.
REQ-016 o_eof SHALL assert with o_tlast on the final forwarded beat of the frame (last LTF beat when count is 0).
REQ-017 num_symbols SHALL be registered on num_symbols_valid, clamped to MAX_NUM_SYMBOLS; frame count latched on sof acceptance; mid-frame updates apply next frame.
REQ-018 i_sof accepted in any state other than IDLE SHALL abort current frame, restart at GUARD with that beat counted; any forwarded symbol in progress is not completed and gets no o_tlast/o_eof.
REQ-019 In discard states i_tready SHALL be 1 irrespective of o_tready.
REQ-020 In forward states i_tready SHALL equal (~o_tvalid | o_tready); output is one registered stage, latency 1 cycle from input accept to o_tvalid.
REQ-021 Output beat SHALL hold o_tdata/o_tlast/o_sof/o_eof stable while o_tvalid & ~o_tready.
REQ-022 Simultaneous output handoff and new input accept SHALL sustain one beat/cycle, no bubble.
REQ-023 o_sof, o_eof SHALL be meaningful only with o_tvalid.

Reset
REQ-024 On reset: state IDLE, counters 0, o_tvalid 0, o_tlast 0, o_sof 0, o_eof 0, o_tdata 0.
REQ-025 On reset: registered num_symbols SHALL be 0.
REQ-026 Reset mid-frame SHALL drop the held output beat; next output only after a new i_sof.
REQ-027 i_tready SHALL be 0 in the cycle reset is asserted.

Configuration
REQ-028 Macro OFDM_CP_REMOVE_BACKOFF_EN SHALL select FFT window backoff.
REQ-029 Without it: CP state discards exactly CYCLIC_PREFIX_LEN beats per data symbol.
REQ-030 With it: CP discards CYCLIC_PREFIX_LEN-CP_BACKOFF beats, DATA forwards SYMBOL_LEN, then CP_BACKOFF trailing beats discarded before next CP; LTF path unchanged; elaboration error if CP_BACKOFF >= CYCLIC_PREFIX_LEN.

Structure
REQ-031 Package ofdm_pkg SHALL hold state enum and defaults for SYMBOL_LEN, CYCLIC_PREFIX_LEN, PREAMBLE_LEN, MAX_NUM_SYMBOLS.
REQ-032 Output register stage SHALL be sub-module axi_fifo_flop (WIDTH 35); control counters stay in top.

Verification
REQ-033 num_symbols=2, frame of 160+2*80 ramp samples, o_tready=1 -> 256 output beats, o_tlast at beats 64,128,192,256, o_sof beat 1 = input sample 32, o_eof beat 256.
REQ-034 num_symbols=0 -> 128 output beats, o_eof with second o_tlast, following samples discarded until next i_sof.
REQ-035 o_tready toggled random 50%, num_symbols=3 -> identical output sequence to ready=1 run, no beat lost or duplicated.
REQ-036 second i_sof at input sample 200 of first frame -> no o_eof for frame 1, frame 2 output starts at its sample 32 with o_sof.
REQ-037 num_symbols=15 strobe -> frame carries 10 data symbols; num_symbols changed mid-frame -> current frame unaffected.
REQ-038 OFDM_CP_REMOVE_BACKOFF_EN, CP_BACKOFF=4 -> first data output = frame sample 172, second symbol starts at sample 252.
